// File: rtl/pcm_mm_arbiter.sv
// pcm_mm_arbiter: shares one memory-mapped PCM port among NUM_CPU requesters.
// Fixed priority by default; define PCM_MM_ARB_RR_EN for round-robin grants.
module pcm_mm_arbiter #(
  parameter int NUM_CPU  = 4,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CPU-1:0]        cpu_req,
  input  logic [NUM_CPU-1:0]        cpu_write,
  input  logic [NUM_CPU*ADDR_W-1:0] cpu_addr,
  input  logic [NUM_CPU*DATA_W-1:0] cpu_data_in,
  output logic [NUM_CPU-1:0]        cpu_ready,
  output logic [NUM_CPU*DATA_W-1:0] cpu_data_out,
  output logic [ADDR_W-1:0]         pcm_mem_mm_address,
  output logic                      pcm_mem_mm_chipselect,
  output logic                      pcm_mem_mm_clken,
  output logic                      pcm_mem_mm_write,
  output logic [DATA_W-1:0]         pcm_mem_mm_writedata,
  input  logic [DATA_W-1:0]         pcm_mem_mm_readdata,
  output logic [DATA_W/8-1:0]       pcm_mem_mm_byteenable
);

  localparam int IDX_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_RD, DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0] gnt_q;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_vld;
  logic             wr_q;
  logic [2:0]       cnt_q;
  logic             rd_last;

  assign rd_last = (cnt_q == 3'(READ_LAT-1));
  assign pcm_mem_mm_byteenable = '1;

`ifdef PCM_MM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  int               j;

  // search begins one past the last winner
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_CPU; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_CPU) j = j - NUM_CPU;
      if (!sel_vld && cpu_req[IDX_W'(j)]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (state_q == IDLE && sel_vld) begin
      if (sel_idx == IDX_W'(NUM_CPU-1)) ptr_q <= '0;
      else ptr_q <= sel_idx + 1'b1;
    end
  end
`else
  always_comb begin
    sel_vld = |cpu_req;
    sel_idx = '0;
    for (int k = NUM_CPU-1; k >= 0; k--) begin
      if (cpu_req[IDX_W'(k)]) sel_idx = IDX_W'(k);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_vld) state_d = ISSUE;
      ISSUE:   state_d = wr_q ? DONE : WAIT_RD;
      WAIT_RD: if (rd_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus fields are loaded once at grant and then frozen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q                 <= '0;
      wr_q                  <= 1'b0;
      cnt_q                 <= '0;
      cpu_ready             <= '0;
      cpu_data_out          <= '0;
      pcm_mem_mm_address    <= '0;
      pcm_mem_mm_writedata  <= '0;
      pcm_mem_mm_chipselect <= 1'b0;
      pcm_mem_mm_write      <= 1'b0;
      pcm_mem_mm_clken      <= 1'b0;
    end else begin
      pcm_mem_mm_clken      <= 1'b1;
      pcm_mem_mm_chipselect <= (state_d == ISSUE);
      pcm_mem_mm_write      <= 1'b0;
      cpu_ready             <= '0;
      if (state_q == IDLE && sel_vld) begin
        gnt_q                <= sel_idx;
        wr_q                 <= cpu_write[sel_idx];
        pcm_mem_mm_write     <= cpu_write[sel_idx];
        pcm_mem_mm_address   <=
          cpu_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
        pcm_mem_mm_writedata <=
          cpu_data_in[int'(sel_idx)*DATA_W +: DATA_W];
      end
      cnt_q <= (state_q == WAIT_RD) ? cnt_q + 3'd1 : 3'd0;
      if (state_q == WAIT_RD && rd_last)
        cpu_data_out[int'(gnt_q)*DATA_W +: DATA_W] <=
          pcm_mem_mm_readdata;
      if (state_d == DONE) cpu_ready[gnt_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcm_mm_arbiter.sv
// tb_pcm_mm_arbiter: scoreboard bench for pcm_mm_arbiter with a
// latency-accurate memory model and a wide second instance.
module tb_pcm_mm_arbiter;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int RL = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [N-1:0]    cpu_req, cpu_write, cpu_ready;
  logic [N*AW-1:0] cpu_addr;
  logic [N*DW-1:0] cpu_data_in, cpu_data_out;
  logic [AW-1:0]   mm_addr;
  logic            mm_cs, mm_ck, mm_wr;
  logic [DW-1:0]   mm_wd, mm_rd;
  logic [DW/8-1:0] mm_be;

  logic [7:0]      w_req, w_write, w_ready;
  logic [8*24-1:0] w_addr;
  logic [8*32-1:0] w_din, w_dout;
  logic [23:0]     w_mm_addr;
  logic            w_cs, w_ck, w_wr;
  logic [31:0]     w_wd;
  logic [31:0]     w_rd;
  logic [3:0]      w_be;

  assign w_rd = '0;

  always #5 clk = ~clk;

  pcm_mm_arbiter #(
    .NUM_CPU(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_ready(cpu_ready), .cpu_data_out(cpu_data_out),
    .pcm_mem_mm_address(mm_addr),
    .pcm_mem_mm_chipselect(mm_cs),
    .pcm_mem_mm_clken(mm_ck),
    .pcm_mem_mm_write(mm_wr),
    .pcm_mem_mm_writedata(mm_wd),
    .pcm_mem_mm_readdata(mm_rd),
    .pcm_mem_mm_byteenable(mm_be)
  );

  pcm_mm_arbiter #(
    .NUM_CPU(8), .ADDR_W(24), .DATA_W(32), .READ_LAT(1)
  ) dut_w (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(w_req), .cpu_write(w_write),
    .cpu_addr(w_addr), .cpu_data_in(w_din),
    .cpu_ready(w_ready), .cpu_data_out(w_dout),
    .pcm_mem_mm_address(w_mm_addr),
    .pcm_mem_mm_chipselect(w_cs),
    .pcm_mem_mm_clken(w_ck),
    .pcm_mem_mm_write(w_wr),
    .pcm_mem_mm_writedata(w_wd),
    .pcm_mem_mm_readdata(w_rd),
    .pcm_mem_mm_byteenable(w_be)
  );

  // memory: readdata valid exactly RL cycles after the issue cycle
  logic [DW-1:0] mem [int];
  logic [DW-1:0] rd_pipe [RL];
  logic [RL-1:0] rd_vld = '0;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (mm_cs && mm_wr) mem[int'(mm_addr)] = mm_wd;
    rd_pipe[0] <= mem_val(mm_addr);
    rd_vld[0]  <= mm_cs && !mm_wr;
    for (int i = 1; i < RL; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_vld[i]  <= rd_vld[i-1];
    end
  end

  assign mm_rd = rd_vld[RL-1] ? rd_pipe[RL-1] : 16'hF00D;

  typedef struct {
    int            ch;
    bit            rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [N*DW-1:0] dout_model = '0;
  int            checks = 0;
  int            errors = 0;

  always @(negedge clk) begin
    if (reset_n && cpu_ready !== '0) begin
      exp_t       e;
      logic [N-1:0] oh;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got %b, want 0", cpu_ready);
      end else begin
        e = sb.pop_front();
        oh = '0;
        oh[e.ch] = 1'b1;
        if (e.rd) dout_model[e.ch*DW +: DW] = e.data;
        if (cpu_ready !== oh) begin
          errors++;
          $display("FAIL ready_order: got %b, want %b", cpu_ready, oh);
        end
        checks++;
        if (cpu_data_out !== dout_model) begin
          errors++;
          $display("FAIL data_out: got %h, want %h",
                   cpu_data_out, dout_model);
        end
      end
    end
  end

  task automatic run_txn(input int ch, input bit wr,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         output int lat,
                         output logic [AW-1:0] ia,
                         output logic [DW-1:0] id,
                         output logic iw);
    exp_t e;
    @(posedge clk);
    #1;
    cpu_write[ch] = wr;
    cpu_addr[ch*AW +: AW] = a;
    cpu_data_in[ch*DW +: DW] = d;
    cpu_req[ch] = 1'b1;
    e.ch = ch;
    e.rd = !wr;
    e.data = d;
    sb.push_back(e);
    lat = -1;
    ia = 'x;
    id = 'x;
    iw = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mm_cs) begin
        ia = mm_addr;
        id = mm_wd;
        iw = mm_wr;
      end
      if (cpu_ready[ch]) begin
        lat = i;
        break;
      end
    end
    cpu_req[ch] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = '0;
    cpu_write = '0;
    cpu_addr = '0;
    cpu_data_in = '0;
    w_req = '0;
    w_write = '0;
    w_addr = '0;
    w_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mm_cs, mm_wr, mm_ck} !== 3'b000 || mm_addr !== '0 ||
        mm_wd !== '0) begin
      errors++;
      $display("FAIL reset_bus: got cs%b wr%b ck%b a%h d%h, want zeros",
               mm_cs, mm_wr, mm_ck, mm_addr, mm_wd);
    end
    checks++;
    if (cpu_ready !== '0 || cpu_data_out !== '0 || w_ready !== '0) begin
      errors++;
      $display("FAIL reset_cpu: got rdy%b dout%h, want zeros",
               cpu_ready, cpu_data_out);
    end
    checks++;
    if (mm_be !== 2'b11) begin
      errors++;
      $display("FAIL byteenable: got %b, want 11", mm_be);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mm_ck !== 1'b1 || mm_cs !== 1'b0) begin
      errors++;
      $display("FAIL clken_run: got ck%b cs%b, want ck1 cs0", mm_ck, mm_cs);
    end
  endtask

  task automatic test_write();
    int lat;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    logic iw;
    run_txn(2, 1'b1, 20'h0A5A5, 16'h1234, lat, ia, id, iw);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL write_latency: got %0d, want 2", lat);
    end
    checks++;
    if (ia !== 20'h0A5A5 || id !== 16'h1234 || iw !== 1'b1) begin
      errors++;
      $display("FAIL write_issue: got a%h d%h w%b, want a0a5a5 d1234 w1",
               ia, id, iw);
    end
    run_txn(2, 1'b0, 20'h0A5A5, 16'h1234, lat, ia, id, iw);
    checks++;
    if (lat != 2 + RL || iw !== 1'b0) begin
      errors++;
      $display("FAIL readback: got lat%0d w%b, want lat%0d w0",
               lat, iw, 2 + RL);
    end
  endtask

  task automatic test_read();
    int lat;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    logic iw;
    mem[32'h10] = 16'hBEEF;
    run_txn(3, 1'b0, 20'h00123, 16'h5B79, lat, ia, id, iw);
    run_txn(1, 1'b0, 20'h00010, 16'hBEEF, lat, ia, id, iw);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL read_latency: got %0d, want 5", lat);
    end
    checks++;
    if (ia !== 20'h00010 || iw !== 1'b0) begin
      errors++;
      $display("FAIL read_issue: got a%h w%b, want a00010 w0", ia, iw);
    end
    run_txn(1, 1'b1, 20'h00011, 16'h4321, lat, ia, id, iw);
  endtask

  task automatic test_ignore_changes();
    exp_t e;
    bit   extra;
    @(posedge clk);
    #1;
    cpu_write[0] = 1'b1;
    cpu_addr[0 +: AW] = 20'h11111;
    cpu_data_in[0 +: DW] = 16'hAAAA;
    cpu_req[0] = 1'b1;
    e.ch = 0;
    e.rd = 1'b0;
    e.data = '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cpu_write[0] = 1'b0;
    cpu_addr[0 +: AW] = 20'h22222;
    cpu_data_in[0 +: DW] = 16'h5555;
    cpu_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (mm_cs !== 1'b1 || mm_wr !== 1'b1 || mm_addr !== 20'h11111 ||
        mm_wd !== 16'hAAAA) begin
      errors++;
      $display("FAIL frozen_issue: got cs%b w%b a%h d%h, want 1 1 11111 aaaa",
               mm_cs, mm_wr, mm_addr, mm_wd);
    end
    @(negedge clk);
    checks++;
    if (cpu_ready !== 4'b0001 || mm_cs !== 1'b0 || mm_wr !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: got rdy%b cs%b w%b, want 0001 0 0",
               cpu_ready, mm_cs, mm_wr);
    end
    extra = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ready !== '0 || mm_cs !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL no_rerequest: got activity, want idle");
    end
  endtask

  task automatic test_fixed_priority();
    exp_t e;
    int   n0 = 0, n3 = 0, last = -1;
    bit   gap_bad = 0, early3 = 0;
    @(posedge clk);
    #1;
    cpu_write[0] = 1'b1;
    cpu_write[3] = 1'b1;
    cpu_addr[0 +: AW] = 20'h00100;
    cpu_addr[3*AW +: AW] = 20'h00300;
    cpu_req[0] = 1'b1;
    cpu_req[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.ch = (k < 3) ? 0 : 3;
      e.rd = 1'b0;
      e.data = '0;
      sb.push_back(e);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_ready[3]) begin
        n3++;
        if (n0 < 3) early3 = 1'b1;
        cpu_req[3] = 1'b0;
        break;
      end
      if (cpu_ready[0]) begin
        n0++;
        if (last >= 0 && i - last != 3) gap_bad = 1'b1;
        last = i;
        if (n0 == 3) cpu_req[0] = 1'b0;
      end
    end
    checks++;
    if (n0 != 3 || n3 != 1 || early3) begin
      errors++;
      $display("FAIL fixed_prio: got n0=%0d n3=%0d early=%0d, want 3 1 0",
               n0, n3, early3);
    end
    checks++;
    if (gap_bad) begin
      errors++;
      $display("FAIL back_to_back: got gap!=3, want 3");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   order[5] = '{-1, -1, -1, -1, -1};
    int   exp_order[5] = '{0, 1, 2, 3, 0};
    int   n = 0;
    reset_n = 1'b0;
    #1;
    sb.delete();
    dout_model = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      cpu_write[c] = 1'b1;
      cpu_addr[c*AW +: AW] = AW'(32'h500 + c);
    end
    cpu_req = '1;
    for (int k = 0; k < 5; k++) begin
      e.ch = exp_order[k];
      e.rd = 1'b0;
      e.data = '0;
      sb.push_back(e);
    end
    for (int i = 0; i < 60 && n < 5; i++) begin
      @(negedge clk);
      if (cpu_ready !== '0) begin
        for (int c = 0; c < N; c++) if (cpu_ready[c]) order[n] = c;
        n++;
        if (n == 5) cpu_req = '0;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d, want 5", n);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (order[k] != exp_order[k]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, want %0d",
                 k, order[k], exp_order[k]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen = 0;
    int   lat;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    logic iw;
    @(posedge clk);
    #1;
    cpu_write[1] = 1'b0;
    cpu_addr[1*AW +: AW] = 20'h00040;
    cpu_req[1] = 1'b1;
    e.ch = 1;
    e.rd = 1'b1;
    e.data = 16'h0000;
    sb.push_back(e);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    cpu_req[1] = 1'b0;
    #1;
    sb.delete();
    dout_model = '0;
    checks++;
    if ({mm_cs, mm_wr, mm_ck} !== 3'b000 || mm_addr !== '0 ||
        mm_wd !== '0 || cpu_ready !== '0 || cpu_data_out !== '0) begin
      errors++;
      $display("FAIL mid_reset: got cs%b w%b ck%b a%h d%h rdy%b dout%h, want 0",
               mm_cs, mm_wr, mm_ck, mm_addr, mm_wd, cpu_ready, cpu_data_out);
    end
    repeat (2) begin
      @(negedge clk);
      if (cpu_ready !== '0) seen = 1'b1;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ready !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abandoned_ready: got pulse, want none");
    end
    run_txn(0, 1'b1, 20'h77777, 16'h7777, lat, ia, id, iw);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL post_reset_write: got lat %0d, want 2", lat);
    end
    run_txn(1, 1'b0, 20'h00040, 16'h5A1A, lat, ia, id, iw);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL post_reset_read: got lat %0d, want 5", lat);
    end
  endtask

  task automatic test_wide();
    @(posedge clk);
    #1;
    w_write[7] = 1'b1;
    w_addr[7*24 +: 24] = 24'hFFFFFF;
    w_din[7*32 +: 32] = 32'hDEADBEEF;
    w_req[7] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    w_req[7] = 1'b0;
    checks++;
    if (w_cs !== 1'b1 || w_wr !== 1'b1 || w_mm_addr !== 24'hFFFFFF ||
        w_wd !== 32'hDEADBEEF || w_be !== 4'hF) begin
      errors++;
      $display("FAIL wide_issue: got cs%b w%b a%h d%h be%h, want 1 1 ffffff deadbeef f",
               w_cs, w_wr, w_mm_addr, w_wd, w_be);
    end
    @(negedge clk);
    checks++;
    if (w_ready !== 8'h80 || w_dout !== '0) begin
      errors++;
      $display("FAIL wide_ready: got %b dout %h, want 10000000 0",
               w_ready, w_dout);
    end
    @(negedge clk);
    checks++;
    if (w_ready !== 8'h00 || w_cs !== 1'b0) begin
      errors++;
      $display("FAIL wide_pulse: got rdy%b cs%b, want 0 0", w_ready, w_cs);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_changes();
`ifdef PCM_MM_ARB_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_reset_mid();
    test_wide();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
